// File: rtl/ftdi_fifo_bridge.sv
// Bridges an FTDI synchronous-style FIFO bus to user valid/ready RX and TX streams through two FWFT FIFOs.
// Bus transfers cost RD_CYC or 1+WR_CYC strobe clocks plus PRE_CYC recovery; a full RX or empty TX FIFO blocks that direction.
module ftdi_fifo_bridge #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int RD_CYC  = 4,
  parameter int WR_CYC  = 4,
  parameter int PRE_CYC = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     rxf_n,
  input  logic                     txe_n,
  input  logic [DATA_W-1:0]        adbus_in,
  output logic [DATA_W-1:0]        adbus_out,
  output logic                     adbus_oe,
  output logic                     ftdi_rd_n,
  output logic                     ftdi_wr_n,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  input  logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [$clog2(DEPTH):0]   tx_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXRW = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int MAXC  = (MAXRW > PRE_CYC) ? MAXRW : PRE_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, RD_STROBE, RD_HOLD, WR_SETUP, WR_STROBE, WR_HOLD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         rxf_sync, txe_sync;
  logic               rxf_s, txe_s;
  logic               last_grant;
  logic [DATA_W-1:0]  wr_dat, tx_head;
  logic               rd_ok, wr_ok, rd_last, wr_last, pre_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxf_sync <= 2'b11;
      txe_sync <= 2'b11;
    end else begin
      rxf_sync <= {rxf_sync[0], rxf_n};
      txe_sync <= {txe_sync[0], txe_n};
    end
  end

  assign rxf_s    = rxf_sync[1];
  assign txe_s    = txe_sync[1];
  assign rd_ok    = en && !rxf_s && (rx_count < FULL);
  assign wr_ok    = en && !txe_s && (tx_count != '0);
  assign rd_last  = (state == RD_STROBE) && (cnt == CNT_W'(RD_CYC - 1));
  assign wr_last  = (state == WR_STROBE) && (cnt == CNT_W'(WR_CYC - 1));
  assign pre_last = (cnt == CNT_W'(PRE_CYC - 1));
  assign rx_valid = (rx_count != '0);
  assign tx_ready = (tx_count != FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      // last_grant=1 means the previous grant went to the write side
      IDLE:      if (rd_ok && (!wr_ok || last_grant)) state_next = RD_STROBE;
                 else if (wr_ok)                      state_next = WR_SETUP;
      RD_STROBE: if (rd_last)  state_next = RD_HOLD;
      RD_HOLD:   if (pre_last) state_next = IDLE;
      WR_SETUP:  state_next = WR_STROBE;
      WR_STROBE: if (wr_last)  state_next = WR_HOLD;
      WR_HOLD:   if (pre_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ftdi_rd_n = 1'b1;
    ftdi_wr_n = 1'b1;
    adbus_oe  = 1'b0;
    adbus_out = wr_dat;
    case (state)
      RD_STROBE: ftdi_rd_n = 1'b0;
      WR_SETUP:  adbus_oe  = 1'b1;
      WR_STROBE: begin adbus_oe = 1'b1; ftdi_wr_n = 1'b0; end
      WR_HOLD:   adbus_oe  = 1'b1;
      default:   ;
    endcase
  end

  // wr_dat latches the TX head at grant so the bus stays stable after the pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      wr_dat     <= '0;
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      if (state == IDLE && state_next == RD_STROBE) last_grant <= 1'b0;
      if (state == IDLE && state_next == WR_SETUP) begin
        last_grant <= 1'b1;
        wr_dat     <= tx_head;
      end
    end
  end

  ftdi_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_last),
    .push_data (adbus_in),
    .pop       (rx_valid && rx_ready),
    .head      (rx_data),
    .count     (rx_count)
  );

  ftdi_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (wr_last),
    .head      (tx_head),
    .count     (tx_count)
  );
endmodule

// First-word-fall-through FIFO; head is valid combinationally whenever count is non-zero.
// Zero-latency read, one-clock write; callers must not push when full or pop when empty.
module ftdi_fifo_bridge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Bench for ftdi_fifo_bridge: an FTDI device model with byte scoreboards plus directed and random scenarios.
module tb_ftdi_fifo_bridge;
  localparam int DEPTH = 16, RD_CYC = 4, WR_CYC = 4, PRE_CYC = 3;

  logic       clock = 1'b0, reset_n = 1'b0, en = 1'b0, rxf_n = 1'b1, txe_n = 1'b1;
  logic [7:0] adbus_in = 8'h00, adbus_out, rx_data, tx_data = 8'h00;
  logic       adbus_oe, ftdi_rd_n, ftdi_wr_n, rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready;
  logic [4:0] rx_count, tx_count;

  ftdi_fifo_bridge #(.DATA_W(8), .DEPTH(DEPTH), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .PRE_CYC(PRE_CYC)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .rxf_n(rxf_n), .txe_n(txe_n),
    .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
    .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  logic [7:0] host_src[$];   // bytes the FTDI device hands out on reads
  logic [7:0] exp_rx[$];     // bytes read from the bus, not yet popped by the user
  logic [7:0] tx_q[$];       // bytes pushed by the user, not yet written on the bus
  int         order_q[$];    // 0 = read started, 1 = write started
  int         rd_done = 0, wr_done = 0;

  logic       prev_rd = 1'b1, prev_wr = 1'b1, prev_oe = 1'b0;
  int         rd_len = 0, wr_len = 0, high_len = 100;
  logic [7:0] wr_byte = 8'h00;

  // FTDI device model and bus-protocol checker
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_rd = 1'b1; prev_wr = 1'b1; prev_oe = 1'b0;
      rd_len = 0; wr_len = 0; high_len = 100;
    end else begin
      if (!ftdi_rd_n) begin
        checks++;
        if (!ftdi_wr_n || adbus_oe) begin
          errors++; $display("FAIL bus_conflict: wr_n=%0b oe=%0b while rd_n low, required wr_n=1 oe=0", ftdi_wr_n, adbus_oe);
        end
      end
      if (prev_rd && !ftdi_rd_n) begin
        checks++;
        if (high_len < PRE_CYC || prev_oe) begin
          errors++; $display("FAIL rd_start: recovery=%0d prev_oe=%0b, required >=%0d and 0", high_len, prev_oe, PRE_CYC);
        end
        order_q.push_back(0);
      end
      if (prev_wr && !ftdi_wr_n) begin
        checks++;
        if (high_len < PRE_CYC || !prev_oe) begin
          errors++; $display("FAIL wr_start: recovery=%0d setup_oe=%0b, required >=%0d and 1", high_len, prev_oe, PRE_CYC);
        end
        wr_byte = adbus_out;
        order_q.push_back(1);
      end
      if (!ftdi_wr_n) begin
        checks++;
        if (adbus_out !== wr_byte || adbus_oe !== 1'b1) begin
          errors++; $display("FAIL wr_stable: out=%h oe=%0b, required %h and 1", adbus_out, adbus_oe, wr_byte);
        end
      end
      if (!prev_rd && ftdi_rd_n) begin
        checks++;
        if (rd_len != RD_CYC) begin
          errors++; $display("FAIL rd_width: %0d clocks, required %0d", rd_len, RD_CYC);
        end
        if (host_src.size() != 0) exp_rx.push_back(host_src.pop_front());
        else                      exp_rx.push_back(8'h00);
        rd_done++;
      end
      if (!prev_wr && ftdi_wr_n) begin
        checks++;
        if (wr_len != WR_CYC) begin
          errors++; $display("FAIL wr_width: %0d clocks, required %0d", wr_len, WR_CYC);
        end
        checks++;
        if (tx_q.size() == 0) begin
          errors++; $display("FAIL wr_byte: wrote %h, required no write (TX model empty)", wr_byte);
        end else begin
          if (tx_q[0] !== wr_byte) begin
            errors++; $display("FAIL wr_byte: wrote %h, required %h", wr_byte, tx_q[0]);
          end
          void'(tx_q.pop_front());
        end
        wr_done++;
      end
      rd_len   = ftdi_rd_n ? 0 : rd_len + 1;
      wr_len   = ftdi_wr_n ? 0 : wr_len + 1;
      high_len = (ftdi_rd_n && ftdi_wr_n) ? high_len + 1 : 0;
      prev_rd  = ftdi_rd_n;
      prev_wr  = ftdi_wr_n;
      prev_oe  = adbus_oe;
    end
    adbus_in = (host_src.size() != 0) ? host_src[0] : 8'h00;
  end

  task automatic cyc();
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    host_src.delete(); exp_rx.delete(); tx_q.delete(); order_q.delete();
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; rxf_n = 1'b1; txe_n = 1'b1;
    cyc(); cyc();
    checks++;
    if (ftdi_rd_n !== 1'b1 || ftdi_wr_n !== 1'b1) begin
      errors++; $display("FAIL reset_strobes: rd_n=%0b wr_n=%0b, required 1 1", ftdi_rd_n, ftdi_wr_n);
    end
    checks++;
    if (adbus_oe !== 1'b0 || adbus_out !== 8'h00) begin
      errors++; $display("FAIL reset_bus: oe=%0b out=%h, required 0 00", adbus_oe, adbus_out);
    end
    checks++;
    if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
      errors++; $display("FAIL reset_counts: rx=%0d tx=%0d, required 0 0", rx_count, tx_count);
    end
    checks++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flags: rx_valid=%0b tx_ready=%0b, required 0 1", rx_valid, tx_ready);
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    int n, low, high;
    host_src.push_back(8'hA5);
    rx_ready = 1'b0; en = 1'b1; rxf_n = 1'b0;
    n = 0;
    while (ftdi_rd_n && n < 20) begin cyc(); n++; end
    checks++;
    if (ftdi_rd_n !== 1'b0) begin
      errors++; $display("FAIL rd_start_timeout: rd_n=%0b after %0d clocks, required 0", ftdi_rd_n, n);
    end
    rxf_n = 1'b1;
    low = 0; n = 0;
    while (!ftdi_rd_n && n < 20) begin low++; cyc(); n++; end
    checks++;
    if (low != RD_CYC) begin
      errors++; $display("FAIL rd_low_clocks: %0d, required %0d", low, RD_CYC);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || rx_count !== 5'd1) begin
      errors++; $display("FAIL rd_capture: valid=%0b data=%h count=%0d, required 1 a5 1", rx_valid, rx_data, rx_count);
    end
    high = 0;
    for (int i = 0; i < 8; i++) begin
      if (ftdi_rd_n) high++;
      cyc();
    end
    checks++;
    if (high != 8) begin
      errors++; $display("FAIL rd_recovery: rd_n high %0d of 8 clocks, required 8", high);
    end
    rx_ready = 1'b1;
    checks++;
    if (exp_rx.size() == 0 || rx_data !== exp_rx[0]) begin
      errors++; $display("FAIL rd_pop_data: data=%h model_entries=%0d, required model head", rx_data, exp_rx.size());
    end
    if (exp_rx.size() != 0) void'(exp_rx.pop_front());
    cyc();
    rx_ready = 1'b0;
    checks++;
    if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rd_pop_count: count=%0d valid=%0b, required 0 0", rx_count, rx_valid);
    end
  endtask

  task automatic test_single_write();
    int n, low;
    en = 1'b1; txe_n = 1'b1;
    tx_data = 8'h3C; tx_valid = 1'b1;
    if (tx_ready) tx_q.push_back(8'h3C);
    cyc();
    tx_valid = 1'b0;
    checks++;
    if (tx_count !== 5'd1) begin
      errors++; $display("FAIL wr_push_count: %0d, required 1", tx_count);
    end
    txe_n = 1'b0;
    n = 0;
    while (!adbus_oe && n < 20) begin cyc(); n++; end
    checks++;
    if (adbus_oe !== 1'b1 || ftdi_wr_n !== 1'b1 || adbus_out !== 8'h3C) begin
      errors++; $display("FAIL wr_setup: oe=%0b wr_n=%0b out=%h, required 1 1 3c", adbus_oe, ftdi_wr_n, adbus_out);
    end
    cyc();
    low = 0; n = 0;
    while (!ftdi_wr_n && n < 20) begin low++; cyc(); n++; end
    checks++;
    if (low != WR_CYC) begin
      errors++; $display("FAIL wr_low_clocks: %0d, required %0d", low, WR_CYC);
    end
    checks++;
    if (tx_count !== 5'd0) begin
      errors++; $display("FAIL wr_pop_count: %0d, required 0", tx_count);
    end
    txe_n = 1'b1;
    repeat (6) cyc();
  endtask

  task automatic test_rx_full();
    int n, base;
    en = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 24; i++) host_src.push_back(8'($urandom));
    rxf_n = 1'b0;
    n = 0;
    while (rx_count < 5'd16 && n < 400) begin cyc(); n++; end
    checks++;
    if (rx_count !== 5'd16) begin
      errors++; $display("FAIL rx_full_count: %0d, required 16", rx_count);
    end
    base = rd_done;
    repeat (40) cyc();
    checks++;
    if (rd_done != base || ftdi_rd_n !== 1'b1) begin
      errors++; $display("FAIL rx_full_stall: %0d extra reads, required 0", rd_done - base);
    end
    rx_ready = 1'b1;
    checks++;
    if (exp_rx.size() == 0 || rx_data !== exp_rx[0]) begin
      errors++; $display("FAIL rx_full_pop: data=%h, required model head", rx_data);
    end
    if (exp_rx.size() != 0) void'(exp_rx.pop_front());
    cyc();
    rx_ready = 1'b0;
    n = 0;
    while (rd_done == base && n < 40) begin cyc(); n++; end
    checks++;
    if (rd_done != base + 1 || rx_count !== 5'd16) begin
      errors++; $display("FAIL rx_full_resume: reads=%0d count=%0d, required 1 16", rd_done - base, rx_count);
    end
    rxf_n = 1'b1;
    repeat (10) cyc();
    rx_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (rx_valid) begin
        checks++;
        if (exp_rx.size() == 0 || rx_data !== exp_rx[0]) begin
          errors++; $display("FAIL rx_drain_data: data=%h, required model head", rx_data);
        end
        if (exp_rx.size() != 0) void'(exp_rx.pop_front());
      end
      cyc();
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_count !== 5'd0 || exp_rx.size() != 0) begin
      errors++; $display("FAIL rx_drain_empty: count=%0d model=%0d, required 0 0", rx_count, exp_rx.size());
    end
  endtask

  task automatic test_en_drop();
    int n, base;
    host_src.delete();
    host_src.push_back(8'h5A);
    rx_ready = 1'b0; en = 1'b1; rxf_n = 1'b0;
    base = rd_done;
    n = 0;
    while (ftdi_rd_n && n < 20) begin cyc(); n++; end
    en = 1'b0;
    repeat (30) cyc();
    checks++;
    if (rd_done != base + 1 || ftdi_rd_n !== 1'b1) begin
      errors++; $display("FAIL en_drop_reads: %0d reads, required 1", rd_done - base);
    end
    checks++;
    if (rx_count !== 5'd1 || rx_data !== 8'h5A) begin
      errors++; $display("FAIL en_drop_data: count=%0d data=%h, required 1 5a", rx_count, rx_data);
    end
    rxf_n = 1'b1; rx_ready = 1'b1;
    if (exp_rx.size() != 0) void'(exp_rx.pop_front());
    cyc();
    rx_ready = 1'b0; en = 1'b1;
    cyc();
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    en = 1'b1; rxf_n = 1'b1; txe_n = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_data = 8'($urandom); tx_valid = 1'b1;
      tx_q.push_back(tx_data);
      cyc();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) host_src.push_back(8'($urandom));
    order_q.delete();
    rxf_n = 1'b0; txe_n = 1'b0;
    n = 0;
    while (order_q.size() < 4 && n < 200) begin cyc(); n++; end
    rxf_n = 1'b1; txe_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= order_q.size() || order_q[i] != i % 2) begin
        errors++; $display("FAIL contention_order[%0d]: got %0d, required %0d (0=read 1=write)",
                           i, (i < order_q.size()) ? order_q[i] : -1, i % 2);
      end
    end
    repeat (20) cyc();
    checks++;
    if (tx_count !== 5'd0 || tx_q.size() != 0) begin
      errors++; $display("FAIL contention_tx_done: count=%0d model=%0d, required 0 0", tx_count, tx_q.size());
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_valid) begin
        checks++;
        if (exp_rx.size() == 0 || rx_data !== exp_rx[0]) begin
          errors++; $display("FAIL contention_rx_data: data=%h, required model head", rx_data);
        end
        if (exp_rx.size() != 0) void'(exp_rx.pop_front());
      end
      cyc();
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    en = 1'b1; txe_n = 1'b1;
    tx_data = 8'hC3; tx_valid = 1'b1;
    tx_q.push_back(8'hC3);
    cyc();
    tx_valid = 1'b0; txe_n = 1'b0;
    n = 0;
    while (ftdi_wr_n && n < 40) begin cyc(); n++; end
    cyc();
    reset_n = 1'b0;
    #1;
    checks++;
    if (ftdi_wr_n !== 1'b1 || adbus_oe !== 1'b0 || ftdi_rd_n !== 1'b1) begin
      errors++; $display("FAIL reset_mid_wr_bus: wr_n=%0b oe=%0b rd_n=%0b, required 1 0 1", ftdi_wr_n, adbus_oe, ftdi_rd_n);
    end
    checks++;
    if (tx_count !== 5'd0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_wr_fifo: tx_count=%0d tx_ready=%0b, required 0 1", tx_count, tx_ready);
    end
    cyc();
    reset_n = 1'b1; txe_n = 1'b1;
    tx_q.delete(); exp_rx.delete(); host_src.delete(); order_q.delete();
    cyc();
  endtask

  task automatic test_random();
    bit drain;
    for (int i = 0; i < 4000; i++) begin
      drain = (i >= 3600);
      checks++;
      if (int'(rx_count) != exp_rx.size()) begin
        errors++; $display("FAIL rnd_rx_count @%0d: %0d, required %0d", i, rx_count, exp_rx.size());
      end
      checks++;
      if (rx_valid !== (exp_rx.size() != 0)) begin
        errors++; $display("FAIL rnd_rx_valid @%0d: %0b, required %0b", i, rx_valid, exp_rx.size() != 0);
      end
      if (rx_valid && exp_rx.size() != 0) begin
        checks++;
        if (rx_data !== exp_rx[0]) begin
          errors++; $display("FAIL rnd_rx_data @%0d: %h, required %h", i, rx_data, exp_rx[0]);
        end
      end
      checks++;
      if (int'(tx_count) != tx_q.size()) begin
        errors++; $display("FAIL rnd_tx_count @%0d: %0d, required %0d", i, tx_count, tx_q.size());
      end
      checks++;
      if (tx_ready !== (tx_q.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_tx_ready @%0d: %0b, required %0b", i, tx_ready, tx_q.size() != DEPTH);
      end
      while (host_src.size() < 4) host_src.push_back(8'($urandom));
      if (!drain) begin
        if ($urandom_range(7) == 0) rxf_n = ~rxf_n;
        if ($urandom_range(7) == 0) txe_n = ~txe_n;
        en       = ($urandom_range(9) != 0);
        rx_ready = 1'($urandom_range(1));
        tx_valid = 1'($urandom_range(1));
        tx_data  = 8'($urandom);
      end else begin
        en = 1'b1; rxf_n = 1'b1; txe_n = 1'b0; rx_ready = 1'b1; tx_valid = 1'b0;
      end
      if (rx_valid && rx_ready && exp_rx.size() != 0) void'(exp_rx.pop_front());
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      cyc();
    end
    checks++;
    if (tx_q.size() != 0 || exp_rx.size() != 0 || rx_count !== 5'd0 || tx_count !== 5'd0) begin
      errors++; $display("FAIL rnd_drained: tx_model=%0d rx_model=%0d rx=%0d tx=%0d, required all 0",
                         tx_q.size(), exp_rx.size(), rx_count, tx_count);
    end
    txe_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_rx_full();
    test_en_drop();
    test_contention();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
